// File: rtl/servo_arm_if.sv
// Switch / servo bundle for the useless-box arm array.
// Switches flow into the controller; PWM, busy and fault flow out.
interface servo_arm_if #(
   parameter int N_CH = 10
);
   logic [N_CH-1:0] switch;
   logic [N_CH-1:0] pwm;
   logic [N_CH-1:0] busy;
   logic [N_CH-1:0] fault;

   modport master (
      output switch,
      input  pwm,
      input  busy,
      input  fault
   );

   modport slave (
      input  switch,
      output pwm,
      output busy,
      output fault
   );
endinterface

// File: rtl/servo_arm_array.sv
// N-channel useless-box controller: one arm FSM and PWM per switch,
// shared frame timebase, index-priority arbitration of moving arms.
module servo_arm_array #(
   parameter int N_CH           = 10,
   parameter int PERIOD         = 1_000_000,
   parameter int PULSE_REST     = 50_000,
   parameter int PULSE_PUSH     = 100_000,
   parameter int RETRACT_FRAMES = 25,
   parameter int PUSH_TIMEOUT   = 50,
   parameter int MAX_ACTIVE     = 2
) (
   input  logic      clk,
   input  logic      reset,
   servo_arm_if.slave bus
);

   localparam int CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int FMAX = (PUSH_TIMEOUT > RETRACT_FRAMES) ?
                         PUSH_TIMEOUT : RETRACT_FRAMES;
   localparam int FW   = (FMAX > 1) ? $clog2(FMAX) : 1;
   localparam int AW   = $clog2(N_CH + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] P_PUSH   = CW'(PULSE_PUSH);
   localparam logic [CW-1:0] P_REST   = CW'(PULSE_REST);
   localparam logic [FW-1:0] PUSH_END = FW'(PUSH_TIMEOUT - 1);
   localparam logic [FW-1:0] RET_END  = FW'(RETRACT_FRAMES - 1);
   localparam logic [AW-1:0] MAX_ACT  = AW'(MAX_ACTIVE);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      PUSH,
      RETRACT
   } state_e;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_CH-1:0] sw_meta_q, sw_meta_d;
   logic [N_CH-1:0] sw_s_q, sw_s_d;
   logic [N_CH-1:0] pwm_q, pwm_d;
   logic [N_CH-1:0] fault_q, fault_d;
   state_e          st_q [N_CH];
   state_e          st_d [N_CH];
   logic [FW-1:0]   fc_q [N_CH];
   logic [FW-1:0]   fc_d [N_CH];

   logic            tick;
   logic [AW-1:0]   active;
   logic [AW-1:0]   slots;
   logic [AW-1:0]   granted;

   always_comb begin
      tick      = (cnt_q == CNT_LAST);
      cnt_d     = tick ? '0 : cnt_q + CW'(1);
      sw_meta_d = bus.switch;
      sw_s_d    = sw_meta_q;
      fault_d   = fault_q;
      pwm_d     = '0;
      bus.busy  = '0;

      // Slots are counted from pre-tick state, so a retracting arm
      // returning to IDLE frees its slot only on the following tick.
      active = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (st_q[i] == PUSH || st_q[i] == RETRACT)
            active = active + AW'(1);
      end
      slots   = MAX_ACT - active;
      granted = '0;

      for (int i = 0; i < N_CH; i++) begin
         st_d[i] = st_q[i];
         fc_d[i] = fc_q[i];
         if (tick) begin
            unique case (st_q[i])
               IDLE: begin
                  if (sw_s_q[i]) st_d[i] = WAIT;
               end
               WAIT: begin
                  if (!sw_s_q[i]) begin
                     st_d[i] = IDLE;
                  end else if (granted < slots) begin
                     st_d[i] = PUSH;
                     fc_d[i] = '0;
                     granted = granted + AW'(1);
                  end
               end
               PUSH: begin
                  if (!sw_s_q[i]) begin
                     st_d[i] = RETRACT;
                     fc_d[i] = '0;
                  end else if (fc_q[i] == PUSH_END) begin
                     st_d[i]    = RETRACT;
                     fc_d[i]    = '0;
                     fault_d[i] = 1'b1;
                  end else begin
                     fc_d[i] = fc_q[i] + FW'(1);
                  end
               end
               RETRACT: begin
                  if (fc_q[i] == RET_END) begin
                     st_d[i] = IDLE;
                     fc_d[i] = '0;
                  end else begin
                     fc_d[i] = fc_q[i] + FW'(1);
                  end
               end
            endcase
         end
         pwm_d[i]    = cnt_q < ((st_q[i] == PUSH) ? P_PUSH : P_REST);
         bus.busy[i] = (st_q[i] != IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         sw_meta_q <= '0;
         sw_s_q    <= '0;
         pwm_q     <= '0;
         fault_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i] <= IDLE;
            fc_q[i] <= '0;
         end
      end else begin
         cnt_q     <= cnt_d;
         sw_meta_q <= sw_meta_d;
         sw_s_q    <= sw_s_d;
         pwm_q     <= pwm_d;
         fault_q   <= fault_d;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i] <= st_d[i];
            fc_q[i] <= fc_d[i];
         end
      end
   end

   assign bus.pwm   = pwm_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_servo_arm_array.sv
// Randomised scoreboard bench for servo_arm_array against a
// frame-level reference model of the arm rules.
module tb_servo_arm_array;

   localparam int N  = 4;
   localparam int P  = 20;
   localparam int PR = 2;
   localparam int PP = 6;
   localparam int RF = 2;
   localparam int PT = 5;
   localparam int MA = 1;

   localparam int S_IDLE = 0;
   localparam int S_WAIT = 1;
   localparam int S_PUSH = 2;
   localparam int S_RET  = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   servo_arm_if #(.N_CH(N)) bus ();

   servo_arm_array #(
      .N_CH(N), .PERIOD(P), .PULSE_REST(PR), .PULSE_PUSH(PP),
      .RETRACT_FRAMES(RF), .PUSH_TIMEOUT(PT), .MAX_ACTIVE(MA)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   typedef struct packed {
      logic [N-1:0] pwm;
      logic [N-1:0] busy;
      logic [N-1:0] fault;
   } obs_t;

   obs_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   done  = 1'b0;

   // Reference model state
   int           m_st [N];
   int           m_fr [N];
   logic [N-1:0] m_flt;
   logic [N-1:0] m_pwm;
   logic [N-1:0] h1, h2;
   int           cyc;
   int           max_moving;

   function automatic void model_edge(bit r, logic [N-1:0] sw);
      int pos, moving, free;
      int ns [N];
      if (r) begin
         cyc = 0; m_flt = '0; m_pwm = '0; h1 = '0; h2 = '0;
         for (int i = 0; i < N; i++) begin
            m_st[i] = S_IDLE; m_fr[i] = 0;
         end
         return;
      end
      pos = cyc % P;
      for (int i = 0; i < N; i++)
         m_pwm[i] = (pos < ((m_st[i] == S_PUSH) ? PP : PR));
      if (pos == P - 1) begin
         moving = 0;
         for (int i = 0; i < N; i++)
            if (m_st[i] == S_PUSH || m_st[i] == S_RET) moving++;
         free = MA - moving;
         for (int i = 0; i < N; i++) begin
            ns[i] = m_st[i];
            if (m_st[i] == S_IDLE) begin
               if (h2[i]) ns[i] = S_WAIT;
            end else if (m_st[i] == S_WAIT) begin
               if (!h2[i]) ns[i] = S_IDLE;
               else if (free > 0) begin
                  ns[i] = S_PUSH; m_fr[i] = 0; free--;
               end
            end else if (m_st[i] == S_PUSH) begin
               if (!h2[i]) begin
                  ns[i] = S_RET; m_fr[i] = 0;
               end else if (m_fr[i] == PT - 1) begin
                  ns[i] = S_RET; m_fr[i] = 0; m_flt[i] = 1'b1;
               end else m_fr[i]++;
            end else begin
               if (m_fr[i] == RF - 1) begin
                  ns[i] = S_IDLE; m_fr[i] = 0;
               end else m_fr[i]++;
            end
         end
         moving = 0;
         for (int i = 0; i < N; i++) begin
            m_st[i] = ns[i];
            if (ns[i] == S_PUSH || ns[i] == S_RET) moving++;
         end
         if (moving > max_moving) max_moving = moving;
      end
      h2 = h1;
      h1 = sw;
      cyc++;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.pwm   = m_pwm;
      o.fault = m_flt;
      for (int i = 0; i < N; i++) o.busy[i] = (m_st[i] != S_IDLE);
      return o;
   endfunction

   // Monitor: the DUT presents a fresh output every cycle
   always @(negedge clk) begin
      if (!done && exp_q.size() > 0) begin
         obs_t e, a;
         e = exp_q.pop_front();
         a = {bus.pwm, bus.busy, bus.fault};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL outputs t=%0t pwm=%b exp %b busy=%b exp %b fault=%b exp %b",
                     $time, a.pwm, e.pwm, a.busy, e.busy, a.fault, e.fault);
         end
      end
   end

   initial begin
      int rate, rst_left, timeout;
      max_moving = 0;
      reset      = 1'b1;
      bus.switch = '1;
      repeat (3) begin
         @(posedge clk);
         model_edge(1'b1, bus.switch);
         #1 exp_q.push_back(model_obs());
      end
      reset      = 1'b0;
      bus.switch = '0;
      rst_left   = 0;
      for (int c = 0; c < 9000; c++) begin
         @(posedge clk);
         model_edge(reset, bus.switch);
         #1 exp_q.push_back(model_obs());
         rate = (c < 3000) ? 90 : (c < 6000) ? 260 : 35;
         for (int i = 0; i < N; i++)
            if ($urandom_range(rate - 1) == 0) bus.switch[i] = ~bus.switch[i];
         if (rst_left > 0) begin
            rst_left--;
         end else if (c == 4500 || $urandom_range(2499) == 0) begin
            rst_left = $urandom_range(3, 1);
         end
         reset = (rst_left > 0);
      end
      timeout = 0;
      while (exp_q.size() > 0 && timeout < 10) begin
         @(posedge clk);
         timeout++;
      end
      if (exp_q.size() > 0) begin
         fails++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      tests++;
      if (max_moving > MA) begin
         fails++;
         $display("FAIL model_active got=%0d limit=%0d", max_moving, MA);
      end
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
